kp_host: RTL and testbench
==========================

KP_HOST -- requirements
Module: kp_host

Interface
REQ-001 Parameter HALF_PERIOD, default 4: CLK cycles per KP_CLK half-phase; legal range 3..255.
REQ-002 Parameter LATCH_LEN, default 8: CLK cycles KP_LATCH is held high per scan; legal range 1..255.
REQ-003 CLK  in  1  single core clock; all logic rises on posedge CLK.
REQ-004 RESn  in  1  reset, asynchronous assert, active-low.
REQ-005 START  in  1  scan request, sampled every CLK.
REQ-006 BUSY  out  1  scan in progress.
REQ-007 DONE  out  1  one-cycle pulse: DATA0/DATA1/PRESENT updated this cycle.
REQ-008 DATA0, DATA1  out  32 each  last completed scan, port 0/1, active-high (1 = pressed/asserted).
REQ-009 PRESENT  out  2  per-port device ID valid from last completed scan.
REQ-010 KP_LATCH, KP_CLK  out  2 each  per-port latch and shift clock; both bits always driven identically.
REQ-011 KP_RW  out  2  constant 2'b11 (read direction).
REQ-012 KP_DOUT  out  2  constant 2'b00.
REQ-013 KP_DIN  in  2  per-port serial data, active-low on the wire.

Function
REQ-014 FSM states: IDLE, LATCH, LOW, HIGH; all outputs registered.
REQ-015 IDLE: KP_LATCH=00, KP_CLK=00, BUSY=0; START=1 at edge n -> LATCH from cycle n+1; START in any other state ignored, not queued.
REQ-016 LATCH: KP_LATCH=11, KP_CLK=00, exactly LATCH_LEN cycles, then LOW with bit index k=0.
REQ-017 LOW: KP_LATCH=00, KP_CLK=00, HALF_PERIOD cycles; on the last LOW cycle capture ~KP_DIN[p] into shift bit k for each port p.
REQ-018 HIGH: KP_CLK=11, HALF_PERIOD cycles; then if k=31 -> IDLE, else k<=k+1 and -> LOW; 5-bit k, no wrap past 31.
REQ-019 32 LOW/HIGH slots per scan; the final clock rising edge is issued even though no further bit is sampled.
REQ-020 BUSY=1 from cycle n+1 through the last HIGH cycle, i.e. exactly LATCH_LEN+64*HALF_PERIOD cycles.
REQ-021 In the first IDLE cycle after the scan: DATA0/DATA1 load the capture registers, PRESENT[p] <= (DATAp[31:28]==4'hF), DONE=1 for that single cycle.
REQ-022 DATA0/DATA1/PRESENT hold previous values for the whole scan; they change only on DONE.
REQ-023 START asserted in the DONE cycle starts a new scan the next cycle (back-to-back, no gap beyond that cycle).
REQ-024 Ports are captured in parallel; a disconnected port (KP_DIN stuck 1) yields DATAp=0, PRESENT[p]=0.
REQ-025 KP_DIN used directly (same clock domain); HALF_PERIOD>=3 covers the device's two-cycle edge-to-data delay.

Reset
REQ-026 RESn low, at any time including mid-scan: FSM -> IDLE, k=0, KP_LATCH=00, KP_CLK=00, BUSY=0, DONE=0, DATA0=DATA1=0, PRESENT=00, capture registers=0.
REQ-027 After RESn deasserts, no activity until START; a scan aborted by reset never produces DONE.

Verification
REQ-028 Device model on port 0 with parallel word 0xF000_1081, port 1 floating (DIN=1); defaults; START pulse -> DONE exactly 1+8+256 cycles after START edge; DATA0=0xF000_1081, DATA1=0, PRESENT=01.
REQ-029 Waveform check, defaults: KP_LATCH high 8 cycles; then 32 KP_CLK pulses, each 4 low + 4 high; BUSY high 264 cycles; KP_RW=11, KP_DOUT=00 throughout.
REQ-030 Both ports with device words 0xF000_4FFF and 0xF000_0000; START held high continuously -> successive DONE pulses 265 cycles apart; PRESENT=11 each scan; DATA stable between DONEs.
REQ-031 Change device word 0xF000_0001 -> 0xF000_0002 mid-scan; DATA0 keeps 0xF000_0001 until that scan's DONE, then the following scan yields 0xF000_0002.
REQ-032 Assert RESn low at cycle 100 of a scan -> all outputs zero within the same cycle, no DONE; new START after release -> full correct scan.
REQ-033 HALF_PERIOD=3, LATCH_LEN=1 with device model -> DATA0 bit-exact for 0xF5A5_A5A5; DONE 1+1+192 cycles after START.

Source files
------------

// File: rtl/kp_host.sv
// Dual-port serial keypad/controller scan host: latch pulse, then 32 clocked bit slots per port.
// Latency: DONE pulses LATCH_LEN+64*HALF_PERIOD cycles after the START-accepting edge.
// Backpressure: none; START is ignored while a scan runs, and results are held until the next DONE.
//
// Ports:
//   CLK, RESn          core clock, async active-low reset
//   START              scan request (accepted only while idle, including the DONE cycle)
//   BUSY, DONE         scan in progress / one-cycle result-update strobe
//   DATA0, DATA1       last completed 32-bit scan per port, active-high
//   PRESENT            per-port device ID (top nibble 4'hF) seen in last scan
//   KP_LATCH, KP_CLK   latch and shift clock, same value on both bits
//   KP_RW, KP_DOUT     constant read direction / zero data toward the devices
//   KP_DIN             per-port serial data, active-low on the wire
module kp_host #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned LATCH_LEN   = 8
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] DATA0,
  output logic [31:0] DATA1,
  output logic [1:0]  PRESENT,
  output logic [1:0]  KP_LATCH,
  output logic [1:0]  KP_CLK,
  output logic [1:0]  KP_RW,
  output logic [1:0]  KP_DOUT,
  input  logic [1:0]  KP_DIN
);

  typedef enum logic [1:0] {IDLE, LATCH, LOW, HIGH} state_t;

  state_t      state;
  logic [7:0]  cnt;   // cycles remaining in the current phase, minus one
  logic [4:0]  k;     // bit slot index
  logic [31:0] cap0;
  logic [31:0] cap1;

  assign KP_RW   = 2'b11;
  assign KP_DOUT = 2'b00;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      k        <= 5'd0;
      cap0     <= 32'd0;
      cap1     <= 32'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DATA0    <= 32'd0;
      DATA1    <= 32'd0;
      PRESENT  <= 2'b00;
      KP_LATCH <= 2'b00;
      KP_CLK   <= 2'b00;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state    <= LATCH;
            cnt      <= 8'(LATCH_LEN - 1);
            BUSY     <= 1'b1;
            KP_LATCH <= 2'b11;
          end
        end
        LATCH: begin
          if (cnt == 8'd0) begin
            state    <= LOW;
            cnt      <= 8'(HALF_PERIOD - 1);
            k        <= 5'd0;
            KP_LATCH <= 2'b00;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOW: begin
          if (cnt == 8'd0) begin
            // Sample as late as possible in the low phase so the device's
            // edge-to-data delay has long settled.
            cap0[k] <= ~KP_DIN[0];
            cap1[k] <= ~KP_DIN[1];
            state   <= HIGH;
            cnt     <= 8'(HALF_PERIOD - 1);
            KP_CLK  <= 2'b11;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HIGH: begin
          if (cnt == 8'd0) begin
            KP_CLK <= 2'b00;
            if (k == 5'd31) begin
              // Final rising edge has been issued; publish results in the
              // first idle cycle.
              state   <= IDLE;
              k       <= 5'd0;
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
              DATA0   <= cap0;
              DATA1   <= cap1;
              PRESENT <= {cap1[31:28] == 4'hF, cap0[31:28] == 4'hF};
            end else begin
              state <= LOW;
              k     <= k + 5'd1;
              cnt   <= 8'(HALF_PERIOD - 1);
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kp_host.sv
// Bench for kp_host: default instance checked every cycle against a timeline model,
// plus a fast-parameter instance checked by directed expectations.
// Device models answer each port with a latched 32-bit word, LSB first, active-low.
module tb_kp_host;

  localparam int HP = 4;
  localparam int LL = 8;
  localparam int T  = LL + 64 * HP;   // busy cycles per scan

  logic        clk = 1'b0;
  logic        resn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  din = 2'b11;
  logic        busy, done;
  logic [31:0] data0, data1;
  logic [1:0]  present, kl, kc, rw, dout;

  logic        start_s = 1'b0;
  logic [1:0]  din_s = 2'b11;
  logic        busy_s, done_s;
  logic [31:0] data0_s, data1_s;
  logic [1:0]  present_s, kl_s, kc_s, rw_s, dout_s;

  kp_host dut (
    .CLK(clk), .RESn(resn), .START(start), .BUSY(busy), .DONE(done),
    .DATA0(data0), .DATA1(data1), .PRESENT(present),
    .KP_LATCH(kl), .KP_CLK(kc), .KP_RW(rw), .KP_DOUT(dout), .KP_DIN(din)
  );

  kp_host #(.HALF_PERIOD(3), .LATCH_LEN(1)) dut_s (
    .CLK(clk), .RESn(resn), .START(start_s), .BUSY(busy_s), .DONE(done_s),
    .DATA0(data0_s), .DATA1(data1_s), .PRESENT(present_s),
    .KP_LATCH(kl_s), .KP_CLK(kc_s), .KP_RW(rw_s), .KP_DOUT(dout_s), .KP_DIN(din_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- device models (0,1: dut ports; 2: dut_s port 0) ----------------
  logic [31:0] dev_word [3] = '{32'h0, 32'h0, 32'h0};
  logic        dev_conn [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] shadow   [3] = '{32'h0, 32'h0, 32'h0};
  int          idx      [3] = '{32, 32, 32};
  logic        prev_c   [3] = '{1'b0, 1'b0, 1'b0};
  logic        pipe0    [3] = '{1'b1, 1'b1, 1'b1};
  logic        pipe1    [3] = '{1'b1, 1'b1, 1'b1};
  logic [2:0]  lv, cv;

  always @(negedge clk) begin
    lv = {kl_s[0], kl[1], kl[0]};
    cv = {kc_s[0], kc[1], kc[0]};
    for (int p = 0; p < 3; p++) begin
      if (lv[p]) begin
        idx[p] = 0;
        shadow[p] = dev_word[p];
      end else if (cv[p] && !prev_c[p]) begin
        idx[p] = idx[p] + 1;
      end
      prev_c[p] = cv[p];
      pipe1[p] = pipe0[p];
      if (!dev_conn[p])    pipe0[p] = 1'b1;
      else if (idx[p] < 32) pipe0[p] = ~shadow[p][idx[p][4:0]];
      else                  pipe0[p] = 1'b1;
    end
    din   = {pipe1[1], pipe1[0]};
    din_s = {1'b1, pipe1[2]};
  end

  // ---------------- timeline model of the default instance ----------------
  int          mt = -1;            // cycle index within current scan, -1 when idle
  logic        m_done = 1'b0;
  logic [31:0] m_d0 = 32'h0, m_d1 = 32'h0, s_w0 = 32'h0, s_w1 = 32'h0;
  logic [1:0]  m_pres = 2'b00;

  always @(posedge clk or negedge resn) begin
    if (!resn) begin
      mt = -1; m_done = 1'b0; m_d0 = 32'h0; m_d1 = 32'h0; m_pres = 2'b00;
    end else begin
      m_done = 1'b0;
      if (mt < 0) begin
        if (start) begin
          mt = 0;
          s_w0 = dev_conn[0] ? dev_word[0] : 32'h0;
          s_w1 = dev_conn[1] ? dev_word[1] : 32'h0;
        end
      end else if (mt == T - 1) begin
        mt = -1;
        m_done = 1'b1;
        m_d0 = s_w0;
        m_d1 = s_w1;
        m_pres = {s_w1[31:28] == 4'hF, s_w0[31:28] == 4'hF};
      end else begin
        mt = mt + 1;
      end
    end
  end

  logic e_busy, e_latch, e_clk;
  always @(posedge clk) begin
    #1;
    if (resn) begin
      e_busy  = (mt >= 0);
      e_latch = (mt >= 0) && (mt < LL);
      e_clk   = (mt >= LL) && (((mt - LL) % (2 * HP)) >= HP);
      check("busy",     32'(busy),    32'(e_busy));
      check("done",     32'(done),    32'(m_done));
      check("data0",    data0,        m_d0);
      check("data1",    data1,        m_d1);
      check("present",  32'(present), 32'(m_pres));
      check("kp_latch", 32'(kl),      32'({2{e_latch}}));
      check("kp_clk",   32'(kc),      32'({2{e_clk}}));
      check("kp_rw",    32'(rw),      32'h3);
      check("kp_dout",  32'(dout),    32'h0);
    end
  end

  // Waits for DONE on the selected instance. lat counts edges from the first
  // edge after the call (the START-sampling edge for a fresh pulse).
  task automatic wait_done(input int which, input bit drop_start, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (drop_start) begin
        if (which == 0) start = 1'b0;
        else            start_s = 1'b0;
      end
      if ((which == 0) ? done : done_s) break;
      bcnt += (which == 0) ? int'(busy) : int'(busy_s);
      if (lat >= 1000) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no DONE within %0d cycles (instance %0d)", lat, which);
        break;
      end
    end
  endtask

  int lat, bcnt;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_data0",   data0,        32'h0);
    check("rst_present", 32'(present), 32'h0);
    check("rst_latch",   32'(kl),      32'h0);
    @(negedge clk);
    resn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'h0);

    // Single scan: device on port 0, port 1 floating
    dev_word[0] = 32'hF000_1081; dev_conn[0] = 1'b1;
    dev_conn[1] = 1'b0;
    @(negedge clk); start = 1'b1;
    wait_done(0, 1'b1, lat, bcnt);
    check("scan1_latency", 32'(lat), 32'd265);
    check("scan1_busy_cycles", 32'(bcnt), 32'd264);
    check("scan1_data0", data0, 32'hF000_1081);
    check("scan1_data1", data1, 32'h0);
    check("scan1_present", 32'(present), 32'h1);
    repeat (4) @(posedge clk);

    // START held high: back-to-back scans, both ports present
    dev_word[0] = 32'hF000_4FFF;
    dev_word[1] = 32'hF000_0000; dev_conn[1] = 1'b1;
    @(negedge clk); start = 1'b1;
    wait_done(0, 1'b0, lat, bcnt);
    check("b2b_first_latency", 32'(lat), 32'd265);
    wait_done(0, 1'b0, lat, bcnt);
    check("b2b_spacing1", 32'(lat), 32'd265);
    wait_done(0, 1'b0, lat, bcnt);
    start = 1'b0;
    check("b2b_spacing2", 32'(lat), 32'd265);
    check("b2b_data0", data0, 32'hF000_4FFF);
    check("b2b_data1", data1, 32'hF000_0000);
    check("b2b_present", 32'(present), 32'h3);
    repeat (4) @(posedge clk);

    // Word changes mid-scan: current scan keeps the latched word
    dev_word[0] = 32'hF000_0001;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    dev_word[0] = 32'hF000_0002;
    check("mid_data0_held", data0, 32'hF000_4FFF);
    wait_done(0, 1'b0, lat, bcnt);
    check("mid_data0_old", data0, 32'hF000_0001);
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1;
    wait_done(0, 1'b1, lat, bcnt);
    check("mid_data0_new", data0, 32'hF000_0002);
    repeat (4) @(posedge clk);

    // Reset mid-scan
    dev_word[0] = 32'hF000_1081; dev_conn[1] = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    resn = 1'b0;
    #1;
    check("mrst_busy",    32'(busy),    32'h0);
    check("mrst_done",    32'(done),    32'h0);
    check("mrst_data0",   data0,        32'h0);
    check("mrst_present", 32'(present), 32'h0);
    check("mrst_latch",   32'(kl),      32'h0);
    check("mrst_clk",     32'(kc),      32'h0);
    repeat (2) @(negedge clk);
    resn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); start = 1'b1;
    wait_done(0, 1'b1, lat, bcnt);
    check("post_rst_latency", 32'(lat), 32'd265);
    check("post_rst_data0", data0, 32'hF000_1081);
    check("post_rst_present", 32'(present), 32'h1);

    // Minimum timing parameters on the second instance
    dev_word[2] = 32'hF5A5_A5A5; dev_conn[2] = 1'b1;
    @(negedge clk); start_s = 1'b1;
    wait_done(1, 1'b1, lat, bcnt);
    check("fast_latency", 32'(lat), 32'd194);
    check("fast_busy_cycles", 32'(bcnt), 32'd193);
    check("fast_data0", data0_s, 32'hF5A5_A5A5);
    check("fast_data1", data1_s, 32'h0);
    check("fast_present", 32'(present_s), 32'h1);
    check("fast_rw", 32'(rw_s), 32'h3);
    check("fast_dout", 32'(dout_s), 32'h0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
